// File: rtl/wifi_tx_cp_inserter.sv
// Cyclic-prefix inserter: buffers 64-sample IFFT symbols in a ping-pong RAM and
// replays each one as CP (last CP_LEN samples) followed by the full symbol.
module wifi_tx_cp_inserter #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int N_FFT        = 64,
  parameter int CP_LEN       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] in_re,
  input  logic [SAMPLE_WIDTH-1:0] in_im,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [SAMPLE_WIDTH-1:0] out_re,
  output logic [SAMPLE_WIDTH-1:0] out_im,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    busy
);

  localparam int PW = $clog2(N_FFT);
  localparam int DW = 2 * SAMPLE_WIDTH;
  localparam logic [PW-1:0] PTR_LAST = PW'(N_FFT - 1);
  localparam logic [PW-1:0] PTR_CP   = PW'(N_FFT - CP_LEN);

  // state  | meaning
  // S_IDLE | waiting for the read bank to fill
  // S_CP   | replaying the cyclic prefix (samples N_FFT-CP_LEN..N_FFT-1)
  // S_BODY | replaying the full symbol (samples 0..N_FFT-1)
  typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;

  state_t r_state, w_state_nxt;

  logic [DW-1:0] r_mem [0:2*N_FFT-1];
  logic [DW-1:0] r_rd_data;

  logic          r_wr_bank;
  logic [PW-1:0] r_wr_ptr;
  logic [1:0]    r_full;
  logic [1:0]    r_last_tag;

  logic          r_rd_bank, w_rd_bank_nxt;
  logic [PW-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic          w_rd_en;
  logic          w_clr_full;
  logic          w_wr_en;
  logic          w_wr_done;

  logic r_out_valid;
  logic r_out_first;
  logic r_out_last;

  assign in_ready  = ~r_full[r_wr_bank];
  assign w_wr_en   = in_valid & in_ready;
  assign w_wr_done = w_wr_en && (r_wr_ptr == PTR_LAST);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[{r_wr_bank, r_wr_ptr}] <= {in_re, in_im};
  end

  always_ff @(posedge clk) begin
    if (w_rd_en) r_rd_data <= r_mem[{r_rd_bank, r_rd_ptr}];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_bank  <= 1'b0;
      r_wr_ptr   <= '0;
      r_last_tag <= 2'b00;
    end else if (w_wr_en) begin
      if (w_wr_done) begin
        r_wr_ptr              <= '0;
        r_wr_bank             <= ~r_wr_bank;
        r_last_tag[r_wr_bank] <= in_last;
      end else begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Writer and reader never touch the same bank's flag in one cycle: the
  // writer only completes into an empty bank, the reader only clears a full one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 2'b00;
    end else begin
      if (w_clr_full) r_full[r_rd_bank] <= 1'b0;
      if (w_wr_done)  r_full[r_wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_rd_en       = 1'b0;
    w_clr_full    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt  = S_CP;
          w_rd_ptr_nxt = PTR_CP;
        end
      end
      S_CP: begin
        w_rd_en = 1'b1;
        if (r_rd_ptr == PTR_LAST) begin
          w_rd_ptr_nxt = '0;
          w_state_nxt  = S_BODY;
        end else begin
          w_rd_ptr_nxt = r_rd_ptr + 1'b1;
        end
      end
      S_BODY: begin
        w_rd_en = 1'b1;
        if (r_rd_ptr == PTR_LAST) begin
          w_clr_full    = 1'b1;
          w_rd_bank_nxt = ~r_rd_bank;
          if (r_full[~r_rd_bank]) begin
            w_state_nxt  = S_CP;
            w_rd_ptr_nxt = PTR_CP;
          end else begin
            w_state_nxt  = S_IDLE;
            w_rd_ptr_nxt = '0;
          end
        end else begin
          w_rd_ptr_nxt = r_rd_ptr + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_rd_en;
      r_out_first <= (r_state == S_CP) && (r_rd_ptr == PTR_CP);
      r_out_last  <= (r_state == S_BODY) && (r_rd_ptr == PTR_LAST) && r_last_tag[r_rd_bank];
    end
  end

  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign out_re    = r_out_valid ? r_rd_data[DW-1:SAMPLE_WIDTH] : '0;
  assign out_im    = r_out_valid ? r_rd_data[SAMPLE_WIDTH-1:0]  : '0;
  assign busy      = r_full[0] | r_full[1] | (r_state != S_IDLE);

endmodule

// File: tb/tb_wifi_tx_cp_inserter.sv
// Directed bench for wifi_tx_cp_inserter: default build plus a CP_LEN=8 build
// sharing the same input stimulus for the single-symbol case.
module tb_wifi_tx_cp_inserter;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [SW-1:0] in_re = '0, in_im = '0;
  logic          in_valid = 1'b0, in_last = 1'b0;
  logic          in_ready, out_valid, out_first, out_last, busy;
  logic [SW-1:0] out_re, out_im;
  logic          in8_ready, out8_valid, out8_first, out8_last, busy8;
  logic [SW-1:0] out8_re, out8_im;

  wifi_tx_cp_inserter #(.SAMPLE_WIDTH(SW), .N_FFT(64), .CP_LEN(16)) dut (
    .clk(clk), .reset(reset), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_re(out_re), .out_im(out_im),
    .out_valid(out_valid), .out_first(out_first), .out_last(out_last), .busy(busy));

  wifi_tx_cp_inserter #(.SAMPLE_WIDTH(SW), .N_FFT(64), .CP_LEN(8)) dut8 (
    .clk(clk), .reset(reset), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in8_ready), .out_re(out8_re), .out_im(out8_im),
    .out_valid(out8_valid), .out_first(out8_first), .out_last(out8_last), .busy(busy8));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_err = 0;
  logic [2*SW+1:0] got_q[$], got8_q[$], exp_q[$], exp8_q[$];
  int gcyc_q[$];
  int idle_bad = 0;
  bit saw_stall = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      got_q.push_back({out_first, out_last, out_re, out_im});
      gcyc_q.push_back(cyc);
    end else if (out_re != 0 || out_im != 0 || out_first || out_last) begin
      idle_bad++;
    end
    if (out8_valid) got8_q.push_back({out8_first, out8_last, out8_re, out8_im});
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] s_re(int s, int k);
    return SW'(s * 64 + k);
  endfunction

  function automatic logic [SW-1:0] s_im(int s, int k);
    return SW'(-(s * 64 + k));
  endfunction

  function automatic void push_exp(int s, bit last, int cp, bit to8);
    logic [2*SW+1:0] e;
    int idx;
    for (int i = 0; i < 64 + cp; i++) begin
      idx = (i < cp) ? (64 - cp + i) : (i - cp);
      e = {i == 0, last && (i == 64 + cp - 1), s_re(s, idx), s_im(s, idx)};
      if (to8) exp8_q.push_back(e);
      else     exp_q.push_back(e);
    end
  endfunction

  task automatic send(int s, int k, bit last, output int acc);
    bit rdy;
    acc = -1;
    in_re = s_re(s, k);
    in_im = s_im(s, k);
    in_last = last;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      rdy = in_ready;
      if (!rdy) saw_stall = 1;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic send_sym(int s, bit last, bit gap, int n, output int last_acc);
    int a = 0;
    for (int k = 0; k < n; k++) begin
      send(s, k, last && (k == 63), a);
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    last_acc = a;
  endtask

  task automatic drain();
    int n = 0;
    for (int t = 0; t < 3000; t++) begin
      if (!busy && !out_valid) n++;
      else n = 0;
      if (n >= 4) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic compare(string tag);
    int gaps = 0;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_s%0d", tag, i), got_q[i], exp_q[i]);
    for (int i = 1; i < gcyc_q.size(); i++)
      if (gcyc_q[i] != gcyc_q[i-1] + 1) gaps++;
    chk({tag, "_gaps"}, gaps, 0);
    chk({tag, "_idle_zero"}, idle_bad, 0);
    got_q.delete(); exp_q.delete(); gcyc_q.delete(); got8_q.delete();
    idle_bad = 0;
  endtask

  initial begin
    int acc, acc1, n7ff;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {out_first, out_last}, 0);
    chk("rst_data", {out_re, out_im}, 0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", in_ready, 1);

    // single contiguous symbol, also checked on the CP_LEN=8 build
    saw_stall = 0;
    send_sym(0, 0, 0, 64, acc);
    chk("t1_busy", busy, 1);
    chk("t1_no_stall", saw_stall, 0);
    drain();
    chk("t1_latency", (gcyc_q.size() > 0) ? gcyc_q[0] - acc : -1, 2);
    push_exp(0, 0, 8, 1);
    chk("cp8_count", got8_q.size(), 72);
    for (int i = 0; i < got8_q.size() && i < exp8_q.size(); i++)
      chk($sformatf("cp8_s%0d", i), got8_q[i], exp8_q[i]);
    exp8_q.delete();
    push_exp(0, 0, 16, 0);
    compare("t1");

    // in_valid toggling every other cycle
    send_sym(0, 0, 1, 64, acc);
    drain();
    push_exp(0, 0, 16, 0);
    compare("gap");

    // three streamed symbols, only the third tagged last
    saw_stall = 0;
    send_sym(0, 0, 0, 64, acc);
    send_sym(1, 0, 0, 64, acc);
    send_sym(2, 1, 0, 64, acc);
    chk("t3_stall", saw_stall, 1);
    drain();
    push_exp(0, 0, 16, 0);
    push_exp(1, 0, 16, 0);
    push_exp(2, 1, 16, 0);
    compare("t3");

    // junk offered while both banks are full
    send_sym(0, 0, 0, 64, acc);
    send_sym(1, 0, 0, 64, acc);
    in_re = 12'h7FF; in_im = 12'h7FF; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("junk_ready_low", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    n7ff = 0;
    foreach (got_q[i]) if (got_q[i][2*SW-1:SW] == 12'h7FF) n7ff++;
    chk("junk_absent", n7ff, 0);
    push_exp(0, 0, 16, 0);
    push_exp(1, 0, 16, 0);
    compare("junk");

    // reset mid-symbol discards the partial symbol
    send_sym(1, 0, 0, 30, acc1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", {out_valid, out_first, out_last, out_re, out_im}, 0);
    got_q.delete(); gcyc_q.delete(); idle_bad = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_hold", {out_valid, busy, out_re, out_im}, 0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    send_sym(0, 0, 0, 64, acc);
    drain();
    repeat (20) @(posedge clk);
    #1;
    chk("rst_first_cp", (got_q.size() > 0) ? got_q[0][2*SW-1:SW] : 12'hFFF, 48);
    push_exp(0, 0, 16, 0);
    compare("rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/wifi_tx_cp_inserter.md
Name: wifi_tx_cp_inserter

Overview:
- Sits directly downstream of the WiFi TX IFFT controller and upstream of the DAC/front-end interface.
- Takes 64-sample time-domain OFDM symbols from the IFFT controller and buffers each symbol in a ping-pong RAM.
- Emits each symbol as 80 contiguous samples: 16-sample cyclic prefix (samples 48..63), then samples 0..63.
- The ping-pong RAM lets the next symbol be written while the current one is read out.

Parameters:
- SAMPLE_WIDTH, 12, bit width of the real and imaginary sample words.
- N_FFT, 64, samples per IFFT symbol; power of two.
- CP_LEN, 16, cyclic prefix length; must be less than N_FFT.

Ports:
- clk  in  1  single block clock.
- reset  in  1  asynchronous, active-low reset.
- in_re  in  SAMPLE_WIDTH  IFFT output sample, real part.
- in_im  in  SAMPLE_WIDTH  IFFT output sample, imaginary part.
- in_valid  in  1  input sample valid.
- in_last  in  1  sampled with the final (64th) sample of a symbol; marks the last symbol of the frame.
- in_ready  out  1  block can accept a sample this cycle.
- out_re  out  SAMPLE_WIDTH  output sample, real part.
- out_im  out  SAMPLE_WIDTH  output sample, imaginary part.
- out_valid  out  1  output sample valid.
- out_first  out  1  high with the first CP sample of each symbol.
- out_last  out  1  high with the 80th sample of a symbol tagged in_last.
- busy  out  1  any bank full or reader active.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, except in_ready=1.
  - wr_bank=0, rd_bank=0, wr_ptr=0, full[1:0]=0, last_tag[1:0]=0, reader state=IDLE.
  - Reset mid-symbol discards all buffered data. No partial symbol is emitted after release.
- Storage: two banks, each N_FFT x (2*SAMPLE_WIDTH). Synchronous write; registered read with 1-cycle latency.
- Writer:
  - in_ready = !full[wr_bank].
  - On in_valid && in_ready: write mem[wr_bank][wr_ptr], then wr_ptr++.
  - When wr_ptr==N_FFT-1 is written: set full[wr_bank], set last_tag[wr_bank]=in_last, toggle wr_bank, wr_ptr=0.
  - in_valid gaps are allowed. wr_ptr holds during gaps.
  - in_valid while in_ready=0 is ignored; that sample is not written.
- Reader FSM:
  - IDLE: if full[rd_bank], go to CP with rd_ptr=N_FFT-CP_LEN and issue the read.
  - CP: issue a read each cycle, rd_ptr++. On rd_ptr==N_FFT-1, wrap rd_ptr to 0 and go to BODY.
  - BODY: issue a read each cycle. On rd_ptr==N_FFT-1:
    - clear full[rd_bank] and toggle rd_bank;
    - if full[other bank] is already set, go to CP with rd_ptr=N_FFT-CP_LEN (back-to-back, no idle cycle);
    - otherwise go to IDLE.
- Output timing:
  - out_valid is asserted exactly one cycle after each read is issued, for exactly N_FFT+CP_LEN=80 consecutive cycles per symbol.
  - out_re/out_im are 0 when out_valid=0.
  - Last input sample accepted at edge E (reader idle): first CP sample is visible after edge E+2.
- Flags:
  - out_first: 1 on the first CP sample only.
  - out_last: 1 on the 80th sample only, when that bank's last_tag=1.
- Output has no backpressure; downstream must consume every out_valid cycle.
- Simultaneous events:
  - The writer filling one bank while the reader clears the other is conflict-free.
  - A bank cleared at edge E is writable from cycle E+1 (in_ready rises after E).
- busy = full[0] | full[1] | (state != IDLE).

Test Plan:
- Single symbol, in_re=k and in_im=-k for k=0..63, contiguous -> 80 out_valid cycles with out_re=48..63 then 0..63 and out_im negated to match. out_first on cycle 1 only, out_last=0, first output 2 cycles after the last input.
- Three symbols streamed contiguously, second tagged in_last=0 and third tagged in_last=1 -> in_ready drops while both banks are full. Outputs are 240 gapless out_valid cycles. out_last is high only on output sample 240.
- Input with in_valid toggling every other cycle -> output is identical to the contiguous case. wr_ptr holds during gaps.
- in_valid asserted while in_ready=0 with value 0x7FF -> that value never appears at the output.
- Assert reset low after 30 samples of a symbol, then send a fresh ramp -> all outputs 0 during reset. After release only the fresh 80-sample symbol is emitted, starting with CP value 48.
- CP_LEN=8, N_FFT=64 parameter build -> 72 samples per symbol, starting at sample 56.
